// File: rtl/ipm_distributed_sync_fifo_v1_3.sv
// Single-clock FIFO on distributed RAM with STANDARD or FWFT read mode,
// programmable almost-full/almost-empty thresholds, flush and sticky error flags.
module ipm_distributed_sync_fifo_v1_3 #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter string       READ_MODE  = "STANDARD"
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   water_level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned PW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam bit          FWFT  = (READ_MODE == "FWFT");

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         level_q, level_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic wr_acc;
    logic rd_acc;
    logic ram_nonempty;
    logic ram_rd;

    // Status flags are compares on the registered level / output-stage state.
    assign full         = (level_q == PW'(DEPTH));
    assign empty        = FWFT ? ~valid_q : (level_q == '0);
    assign almost_full  = (level_q >= af_thresh);
    assign almost_empty = (level_q <= ae_thresh);
    assign water_level  = level_q;
    assign rd_data      = rd_data_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    assign wr_acc       = wr_en & ~full & ~clr;
    assign rd_acc       = rd_en & ~empty & ~clr;
    assign ram_nonempty = (wr_ptr_q != rd_ptr_q);

    // RAM is read on an accepted read, or in FWFT whenever the stage can take a word.
    assign ram_rd = FWFT ? (~clr & ram_nonempty & (~valid_q | rd_acc)) : rd_acc;

    always_comb begin
        wr_ptr_d  = wr_ptr_q + PW'(wr_acc);
        rd_ptr_d  = rd_ptr_q + PW'(ram_rd);
        level_d   = level_q;
        valid_d   = 1'b0;
        rd_data_d = rd_data_q;
        ovf_d     = ovf_q | (wr_en & full);
        udf_d     = udf_q | (rd_en & empty);

        if (wr_acc && !rd_acc) begin
            level_d = level_q + PW'(1);
        end else if (rd_acc && !wr_acc) begin
            level_d = level_q - PW'(1);
        end

        if (FWFT) begin
            valid_d = ram_rd | (valid_q & ~rd_acc);
        end

        if (ram_rd) begin
            rd_data_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        end

        if (clr) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
            valid_d   = 1'b0;
            rd_data_d = '0;
            ovf_d     = 1'b0;
            udf_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            valid_q   <= 1'b0;
            rd_data_q <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            valid_q   <= valid_d;
            rd_data_q <= rd_data_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    // Storage array has no reset; contents are don't-care after reset or flush.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

endmodule

// File: doc/ipm_distributed_sync_fifo_v1_3.md
# ipm_distributed_sync_fifo_v1_3

Single-clock FIFO built on distributed (LUT) RAM, the next generation of the distributed FIFO family. It generalises depth and width, adds a selectable first-word-fall-through (FWFT) read mode, and provides runtime-programmable almost-full/almost-empty thresholds. It also adds a synchronous flush and sticky overflow/underflow error flags. It sits in datapath clock domains, such as QSGMII/MAC-side buffering, where no clock crossing is needed.

## Interface
- ADDR_WIDTH, 4: address width, 4–10; DEPTH = 2^ADDR_WIDTH words.
- DATA_WIDTH, 32: data width, 1–256.
- READ_MODE, "STANDARD": "STANDARD" or "FWFT".
- clk  input  1  single clock for all logic.
- rst_n  input  1  reset, asynchronous and active-low; all state is cleared on assertion, and release is synchronous to clk.
- clr  input  1  synchronous flush, active-high.
- wr_data  input  DATA_WIDTH  write data.
- wr_en  input  1  write request.
- rd_en  input  1  read request (in FWFT mode, the pop acknowledge).
- af_thresh  input  ADDR_WIDTH+1  almost-full threshold, sampled every cycle.
- ae_thresh  input  ADDR_WIDTH+1  almost-empty threshold, sampled every cycle.
- rd_data  output  DATA_WIDTH  read data.
- full, empty, almost_full, almost_empty  output  1  status flags.
- water_level  output  ADDR_WIDTH+1  words held, 0..DEPTH.
- overflow, underflow  output  1  sticky error flags.

## Operation
- Accepted write: wr_acc = wr_en & ~full & ~clr. Accepted read: rd_acc = rd_en & ~empty & ~clr.
- Rejected requests change no state apart from the error flags.
- Pointers are ADDR_WIDTH+1 bits wide (wrap bit). Pointers wrap modulo DEPTH with no gap and no lost word.
- water_level counts every stored word, including the FWFT output stage.
  - Write only: +1. Read only: −1. Both accepted: unchanged.
  - Capacity is DEPTH in both read modes.
- full = (water_level == DEPTH).
- almost_full = (water_level >= af_thresh).
- almost_empty = (water_level <= ae_thresh). Compares are unsigned, full width.
- STANDARD mode:
  - empty = (water_level == 0).
  - On rd_acc, the head word is registered to rd_data.
  - rd_data holds its value when no read is accepted.
- FWFT mode:
  - Output stage holds the head word plus a valid bit; empty = ~valid.
  - When the stage is empty, or is being popped, and RAM holds data, the next RAM word loads into the stage.
  - rd_data is valid whenever empty=0. rd_en pops the stage.
- Full and read in the same cycle: the read is accepted and the write is rejected (full is evaluated pre-edge).
- Empty and write in the same cycle: the write is accepted and the read is rejected.
- overflow sets on wr_en & full. underflow sets on rd_en & empty. Both stay set until rst_n or clr.
- clr (synchronous flush):
  - In one cycle, clears pointers, level, FWFT valid, rd_data and error flags to their reset values.
  - wr_en and rd_en are ignored in the clr cycle.
  - RAM contents are don't-care.

## Timing
- Reset values:
  - rd_data=0, water_level=0.
  - empty=1, full=0.
  - almost_empty=1 if ae_thresh>=0 (i.e. always at level 0).
  - almost_full=(af_thresh==0).
  - overflow=0, underflow=0.
- All flags and water_level are derived from registered state and update on the clk edge of the causing event.
- STANDARD latency:
  - Write at edge N makes empty fall after edge N.
  - rd_en accepted at edge M presents data on rd_data after edge M (1-cycle read latency).
- FWFT latency:
  - A write into an empty FIFO at edge N loads the output stage at edge N+1. empty falls and rd_data is valid after N+1.
  - Back-to-back pops sustain 1 word/cycle when RAM is non-empty.
- Throughput: 1 write plus 1 read per cycle in both modes.
- rst_n assertion mid-transfer forces the reset values immediately. The first write after release is accepted at the first edge with rst_n=1.

## Test plan
1. ADDR_WIDTH=4, DATA_WIDTH=8, STANDARD: write 0x00..0x0F (16 words) → full=1 and water_level=16. A 17th write (0xAA) → overflow=1 and the data is dropped. Read 16 → rd_data 0x00..0x0F in order, each one cycle after rd_en; empty=1 after the last read.
2. FWFT: write 0x5A into an empty FIFO → empty falls 2 edges later with rd_data=0x5A before any rd_en. Pop → empty=1 and water_level=0. One extra rd_en → underflow=1.
3. Wrap-around: 40 cycles of simultaneous wr_en/rd_en at level 3 (incrementing data) → water_level stays 3 and the output sequence is gap-free across two pointer wraps.
4. Thresholds: af_thresh=14, ae_thresh=2. Fill from 0 → almost_empty drops at level 3 and almost_full rises at level 14. Change af_thresh to 16 at level 14 → almost_full deasserts on the next cycle.
5. Full with simultaneous read+write: the read is accepted, the write rejected, water_level goes 16→15 and overflow=1. Empty with simultaneous read+write: the write is accepted, water_level goes 0→1 and underflow=1.
6. Assert clr at level 9 with wr_en=1 → next cycle water_level=0, empty=1, error flags are 0 and the write is not stored. Async rst_n pulse mid-burst → outputs reach reset values without a clk edge.
